// File: rtl/csv_pkg.sv
// Shared constants and types for the CSV byte-stream parser.
package csv_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;

  // Per-field status reported alongside each parsed value.
  typedef struct packed {
    logic eol;
    logic empty;
    logic ovf;
    logic bad;
  } csv_flags_t;

  // IDLE: no field open; ACCUM: at least one non-delimiter byte seen.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } csv_state_e;

endpackage

// File: rtl/csv_stream_parser_dec_accum_step.sv
// One decimal accumulation step: next = acc*10 + digit, with overflow detect.
module dec_accum_step #(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [3:0]        digit_i,
  output logic [DATA_W-1:0] next_acc_o,
  output logic              carry_o
);

  logic [DATA_W+3:0] wide;

  // acc*10 as (acc<<3)+(acc<<1); four guard bits hold the worst case 10*2^W-1.
  always_comb begin
    wide       = ({4'b0000, acc_i} << 3) + ({4'b0000, acc_i} << 1)
               + {{DATA_W{1'b0}}, digit_i};
    next_acc_o = wide[DATA_W-1:0];
    carry_o    = |wide[DATA_W+3:DATA_W];
  end

endmodule

// File: rtl/csv_stream_parser.sv
// Streaming CSV parser: ASCII bytes in, one unsigned decimal field out per
// comma / newline / in_last terminator, with index and status flags.
module csv_stream_parser
  import csv_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_value,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_eol,
  output logic              out_empty,
  output logic              out_ovf,
  output logic              out_bad
);

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  csv_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              bad_q, bad_d;
  logic              nonempty_q, nonempty_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  csv_flags_t        out_flags_q, out_flags_d;

  logic              accept;
  logic              is_digit, is_ign, is_comma, is_lf, is_delim;
  logic              term, eol;
  logic [DATA_W-1:0] acc_base, step_acc;
  logic              step_carry;
  logic [DATA_W-1:0] f_acc;
  logic              f_ovf, f_bad, f_ne;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Byte classification.
  always_comb begin
    is_digit = (in_data >= CH_0) && (in_data <= CH_9);
    is_ign   = (in_data == CH_SP) || (in_data == CH_CR);
    is_comma = (in_data == CH_COMMA);
    is_lf    = (in_data == CH_LF);
    is_delim = is_comma || is_lf;
  end

  // No field is open in IDLE, so the accumulator is known to be zero there.
  assign acc_base = (state_q == ST_IDLE) ? '0 : acc_q;

  // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
  dec_accum_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .acc_i     (acc_base),
    .digit_i   (in_data[3:0]),
    .next_acc_o(step_acc),
    .carry_o   (step_carry)
  );

  // Field update, termination and output-register next state.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    bad_d       = bad_q;
    nonempty_d  = nonempty_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q && !out_ready;
    out_value_d = out_value_q;
    out_idx_d   = out_idx_q;
    out_flags_d = out_flags_q;
    f_acc       = acc_base;
    f_ovf       = ovf_q;
    f_bad       = bad_q;
    f_ne        = nonempty_q;
    term        = 1'b0;
    eol         = 1'b0;

    if (accept) begin
      // The byte is applied to the field first so in_last on a digit counts it.
      if (is_digit) begin
        f_ne = 1'b1;
        if (!bad_q) begin
          f_acc = step_acc;
          f_ovf = ovf_q | step_carry;
        end
      end else if (!is_delim && !is_ign) begin
        f_bad = 1'b1;
      end

      term = is_delim || in_last;
      eol  = is_lf || in_last;

      if (term) begin
        out_valid_d       = 1'b1;
        out_value_d       = f_acc;
        out_idx_d         = idx_q;
        out_flags_d.eol   = eol;
        out_flags_d.empty = !f_ne;
        out_flags_d.ovf   = f_ovf;
        out_flags_d.bad   = f_bad;
        acc_d             = '0;
        ovf_d             = 1'b0;
        bad_d             = 1'b0;
        nonempty_d        = 1'b0;
        if (eol) begin
          idx_d = '0;
        end else if (idx_q != IDX_MAX) begin
          idx_d = idx_q + 1'b1;
        end
        state_d = ST_IDLE;
      end else begin
        acc_d      = f_acc;
        ovf_d      = f_ovf;
        bad_d      = f_bad;
        nonempty_d = f_ne;
        state_d    = ST_ACCUM;
      end
    end
  end

  // State, field accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
      nonempty_q  <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_idx_q   <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
      nonempty_q  <= nonempty_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_idx_q   <= out_idx_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_idx   = out_idx_q;
  assign out_eol   = out_flags_q.eol;
  assign out_empty = out_flags_q.empty;
  assign out_ovf   = out_flags_q.ovf;
  assign out_bad   = out_flags_q.bad;

endmodule

// File: doc/csv_stream_parser.md
Name: csv_stream_parser

Overview:
- Synthesisable streaming parser: ASCII byte stream in, unsigned decimal fields out, one per comma/newline-delimited field.
- Hardware successor to the bench-side CSV line helpers, generalised to any field width DATA_W.
- Adds field index, end-of-line, empty-field, overflow and bad-character reporting.
- Sits between the test-vector byte source (UART/DMA byte FIFO) and the hash-core seed/length/expected-digest loaders.

Parameters:
- DATA_W, 64, output field width in bits (>= 4).
- IDX_W, 8, width of the field-index-within-line counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte valid.
- in_ready  out  1  parser accepts byte.
- in_data  in  8  ASCII byte.
- in_last  in  1  final byte of stream; terminates the open field as end-of-line.
- out_valid  out  1  field result valid.
- out_ready  in  1  downstream accepts field.
- out_value  out  DATA_W  parsed value, modulo 2^DATA_W.
- out_idx  out  IDX_W  field index within current line, from 0.
- out_eol  out  1  field terminated by '\n' or in_last.
- out_empty  out  1  field contained no digits.
- out_ovf  out  1  value exceeded 2^DATA_W-1 at some point.
- out_bad  out  1  non-digit, non-ignored character seen in field.

Behaviour:
- Reset (async, rst_n=0): out_valid=0; out_value=0; out_idx=0; all flags 0; accumulator, field flags and index cleared. in_ready is combinational and follows the out_valid rule below.
- Reset mid-field: the partial field is discarded and no output is produced for it.
- Handshake: byte accepted when in_valid && in_ready; in_ready = !out_valid || out_ready.
- Output handshake: output holds stable while out_valid && !out_ready. Throughput is 1 byte/cycle with no bubbles.
- Digit '0'..'9': if field not bad, acc <= acc*10 + (byte-48).
  - Computed at DATA_W+4 bits; acc keeps the low DATA_W bits.
  - Any nonzero upper bit sets sticky ovf. Accumulation continues, wrapped.
  - Field marked non-empty.
- ' ' and '\r': ignored; no flag change.
- Any other non-delimiter byte: sets sticky bad. All later digits in the field are ignored; value is frozen at the digits before it.
- ',' terminates field with eol=0. '\n' terminates field with eol=1.
- in_last on a non-delimiter byte: the byte is processed first, then the field terminates with eol=1.
- in_last on ',' or '\n': terminates field with eol=1.
- Latency: out_valid asserts the cycle after the terminating byte is accepted. out_* are registered.
- On termination:
  - Output regs <= {acc, idx, eol, !nonempty, ovf, bad}.
  - acc, flags cleared.
  - idx <= eol ? 0 : idx+1. idx saturates at 2^IDX_W-1 and does not wrap.
- Empty field (",,", leading ',', lone "\n") emits value 0 with out_empty=1.
- "1,\n" emits two fields: 1, then empty.
- Simultaneous output accept and new terminator in the same cycle: output regs reload; out_valid stays 1. No field is dropped or duplicated.
- State machine: IDLE (no field open) -> ACCUM on the first non-delimiter byte; ACCUM -> IDLE on a terminator.
  - A terminator in IDLE emits an empty field.
  - Output register occupancy is tracked by out_valid only.

Decomposition:
- Shared package csv_pkg:
  - ASCII constants: CH_0, CH_9, CH_COMMA, CH_LF, CH_CR, CH_SP.
  - Packed struct csv_flags_t {eol, empty, ovf, bad}.
- One sub-module, dec_accum_step: combinational acc*10+digit at parameter DATA_W; outputs next_acc and carry_out (ovf).

Test Plan:
- DATA_W=32, "12,345\n" -> (12, idx0, eol0), then (345, idx1, eol1); all flags 0.
- "1,,7" with in_last on '7' -> (1, idx0); (0, idx1, empty=1); (7, idx2, eol1). Next line starts at idx0.
- DATA_W=32: "4294967295\n" -> 0xFFFFFFFF, ovf=0. "4294967296\n" -> value 0, ovf=1.
- "12a3, 5\r\n" -> (12, bad=1, idx0), then (5, idx1, eol1, bad=0).
- "1,2,3\n" with out_ready held low 3 cycles after the first out_valid:
  - in_ready low while the result waits.
  - out_value stable; outputs 1, 2, 3 in order, no loss.
  - Then out_ready=1 continuously -> one field per terminator with no bubbles.
- Feed "98", pulse rst_n low for 2 cycles mid-byte, then "7\n":
  - out_valid=0 during reset.
  - Sole output is (7, idx0, eol1).
